// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and defaults for the APB master arbiter.
//   - apb_arb_state_e : transfer sequencer states
//   - APB_* constants : default bus geometry and timeout
//   - arb_open        : states in which a new command may be accepted
package apb_master_arbiter_pkg;

    localparam int unsigned APB_ADDR_WIDTH     = 32;
    localparam int unsigned APB_DATA_WIDTH     = 32;
    localparam int unsigned APB_NBYTES         = APB_DATA_WIDTH / 8;
    localparam int unsigned APB_NREQ           = 2;
    localparam int unsigned APB_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS,
        ARB_RESP
    } apb_arb_state_e;

    // The response cycle arbitrates exactly like IDLE so back-to-back transfers cost 3 cycles.
    function automatic logic arb_open(apb_arb_state_e s);
        return (s == ARB_IDLE) || (s == ARB_RESP);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 (mod NREQ).
//   req        : request vector
//   last_grant : index of the previously granted requester
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : binary index of the granted requester
//   any_grant  : at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_grant
);

    logic [IW-1:0] idx;

    // Walk the ring starting just after the last winner; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_grant) + int'(k)) % int'(NREQ));
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NREQ command requesters with round-robin arbitration.
//   cmd_*      : per-requester command handshake (packed per requester)
//   cmd_ready  : combinational accept, one-hot or zero, only in IDLE/RESP
//   rsp_*      : registered one-cycle completion to the owning requester
//   P*         : APB master pins; all registered
// A transfer stuck without PREADY for TIMEOUT_CYCLES ACCESS cycles is aborted
// with rsp_err=1 (TIMEOUT_CYCLES=0 disables the abort).
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned NBYTES         = DATA_WIDTH / 8,
    parameter int unsigned NREQ           = APB_NREQ,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [NREQ-1:0]            cmd_valid,
    output logic [NREQ-1:0]            cmd_ready,
    input  logic [NREQ-1:0]            cmd_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] cmd_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] cmd_wdata,
    input  logic [NREQ*NBYTES-1:0]     cmd_strb,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSELx,
    output logic                       PENABLE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic                       PWRITE,
    output logic [NBYTES-1:0]          PSTRB,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH-1:0]      PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned IW = $clog2(NREQ);

    apb_arb_state_e          state_q, state_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                    arb_en_q;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [NBYTES-1:0]       pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]         grant;
    logic [IW-1:0]           grant_idx;
    logic                    any_grant;
    logic                    accept_open;
    logic                    timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req        (cmd_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    // arb_en_q keeps cmd_ready low while reset is asserted.
    assign accept_open = arb_en_q && arb_open(state_q);
    assign cmd_ready   = accept_open ? grant : '0;

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = write_q;
    assign PSTRB     = pstrb_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and output computation for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        write_d      = write_q;
        paddr_d      = paddr_q;
        pstrb_d      = pstrb_q;
        pwdata_d     = pwdata_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            ARB_IDLE, ARB_RESP: begin
                state_d = ARB_IDLE;
                if (accept_open && any_grant) begin
                    state_d      = ARB_SETUP;
                    last_grant_d = grant_idx;
                    write_d      = cmd_write[grant_idx];
                    paddr_d      = cmd_addr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    // Strobe and write data are zeroed for reads.
                    pstrb_d      = cmd_write[grant_idx] ?
                                   cmd_strb[int'(grant_idx) * NBYTES +: NBYTES] : '0;
                    pwdata_d     = cmd_write[grant_idx] ?
                                   cmd_wdata[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH] : '0;
                    tmo_cnt_d    = '0;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                end
            end
            ARB_SETUP: begin
                state_d   = ARB_ACCESS;
                penable_d = 1'b1;
            end
            ARB_ACCESS: begin
                timeout_hit = (TIMEOUT_CYCLES != 0) &&
                              (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
                // PREADY on the last allowed cycle still completes normally.
                if (PREADY) begin
                    state_d                   = ARB_RESP;
                    psel_d                    = 1'b0;
                    penable_d                 = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d               = write_q ? '0 : PRDATA;
                    rsp_err_d                 = PSLVERR;
                end else if (timeout_hit) begin
                    state_d                   = ARB_RESP;
                    psel_d                    = 1'b0;
                    penable_d                 = 1'b0;
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_err_d                 = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= IW'(NREQ - 1);
            tmo_cnt_q    <= '0;
            arb_en_q     <= 1'b0;
            write_q      <= 1'b0;
            paddr_q      <= '0;
            pstrb_q      <= '0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            arb_en_q     <= 1'b1;
            write_q      <= write_d;
            paddr_q      <= paddr_d;
            pstrb_q      <= pstrb_d;
            pwdata_q     <= pwdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: transaction-timing reference
// model (accept cycle + wait count -> expected pin values per cycle) with
// directed scenarios followed by randomized traffic.
module tb_apb_master_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int NR  = 2;
    localparam int TMO = 16;
    localparam int QD  = 256;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [NB-1:0] strb;
        int            w;        // ACCESS cycles with PREADY low before ready
        logic [DW-1:0] prdata;
        logic          slverr;
    } cmd_t;

    logic                PCLK = 1'b0;
    logic                PRESETn;
    logic [NR-1:0]       cmd_valid;
    logic [NR-1:0]       cmd_ready;
    logic [NR-1:0]       cmd_write;
    logic [NR*AW-1:0]    cmd_addr;
    logic [NR*DW-1:0]    cmd_wdata;
    logic [NR*NB-1:0]    cmd_strb;
    logic [NR-1:0]       rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;
    logic                PSELx;
    logic                PENABLE;
    logic [AW-1:0]       PADDR;
    logic                PWRITE;
    logic [NB-1:0]       PSTRB;
    logic [DW-1:0]       PWDATA;
    logic [DW-1:0]       PRDATA;
    logic                PREADY;
    logic                PSLVERR;

    apb_master_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NBYTES         (NB),
        .NREQ           (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSTRB     (PSTRB),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Pending commands per requester.
    cmd_t pend [NR][QD];
    int   head [NR];
    int   tail [NR];

    // Reference model state.
    logic busy;
    cmd_t cur;
    int   cur_req;
    int   t0;
    int   cyc;
    int   last;
    logic rand_gate;

    int   n_checks;
    int   n_pass;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic push(input int r, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] s, input int w,
                        input logic [DW-1:0] prd, input logic err);
        cmd_t c;
        c.write = wr; c.addr = a; c.wdata = d; c.strb = s;
        c.w = w; c.prdata = prd; c.slverr = err;
        pend[r][tail[r]] = c;
        tail[r]++;
    endtask

    // Round-robin rule: first valid requester after the previous winner.
    function automatic int rr_pick(input logic [NR-1:0] v, input int prev);
        for (int k = 1; k <= NR; k++) begin
            if (v[(prev + k) % NR]) return (prev + k) % NR;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, predict and compare outputs, advance model.
    task automatic step();
        int            c;
        int            resp_c;
        int            win;
        logic          open;
        logic          to;
        logic [NR-1:0] v;
        logic [NR-1:0] e_ready;
        logic [NR-1:0] e_rv;
        logic          e_psel;
        logic          e_pen;
        @(negedge PCLK);
        c      = cyc - t0;
        resp_c = 0;
        to     = 1'b0;
        if (busy) begin
            resp_c = 2 + ((cur.w < TMO) ? cur.w + 1 : TMO);
            to     = (cur.w >= TMO);
        end
        open = !busy || (c == resp_c);
        for (int i = 0; i < NR; i++) begin
            v[i] = (head[i] < tail[i]) && (!rand_gate || ($urandom_range(3) != 0));
            if (head[i] < tail[i]) begin
                cmd_write[i]            = pend[i][head[i]].write;
                cmd_addr[i*AW +: AW]    = pend[i][head[i]].addr;
                cmd_wdata[i*DW +: DW]   = pend[i][head[i]].wdata;
                cmd_strb[i*NB +: NB]    = pend[i][head[i]].strb;
            end else begin
                cmd_write[i]            = 1'($urandom_range(1));
                cmd_addr[i*AW +: AW]    = $urandom;
                cmd_wdata[i*DW +: DW]   = $urandom;
                cmd_strb[i*NB +: NB]    = NB'($urandom);
            end
        end
        cmd_valid = v;
        PREADY    = busy && (c >= 2) && (c < resp_c) && (c - 2 == cur.w);
        PRDATA    = PREADY ? cur.prdata : $urandom;
        PSLVERR   = PREADY ? cur.slverr : 1'($urandom_range(1));
        #1;
        win     = open ? rr_pick(v, last) : -1;
        e_ready = (win >= 0) ? NR'(1 << win) : '0;
        e_rv    = (busy && c == resp_c) ? NR'(1 << cur_req) : '0;
        e_psel  = busy && (c >= 1) && (c < resp_c);
        e_pen   = busy && (c >= 2) && (c < resp_c);
        chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        chk("PSELx",     64'(PSELx),     64'(e_psel));
        chk("PENABLE",   64'(PENABLE),   64'(e_pen));
        if (e_psel) begin
            chk("PADDR",  64'(PADDR),  64'(cur.addr));
            chk("PWRITE", 64'(PWRITE), 64'(cur.write));
            chk("PSTRB",  64'(PSTRB),  64'(cur.write ? cur.strb : '0));
            chk("PWDATA", 64'(PWDATA), 64'(cur.write ? cur.wdata : '0));
        end
        if (e_rv != '0) begin
            chk("rsp_rdata", 64'(rsp_rdata), 64'((to || cur.write) ? '0 : cur.prdata));
            chk("rsp_err",   64'(rsp_err),   64'(to ? 1'b1 : cur.slverr));
        end
        if (busy && c == resp_c) busy = 1'b0;
        if (win >= 0) begin
            cur     = pend[win][head[win]];
            head[win]++;
            cur_req = win;
            t0      = cyc;
            busy    = 1'b1;
            last    = win;
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || head[0] < tail[0] || head[1] < tail[1]) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_bound", 64'(n < 3000), 64'(1));
        step();
        step();
    endtask

    task automatic quiet_inputs();
        cmd_valid = '0; cmd_write = '0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_PSELx"},     64'(PSELx),     64'(0));
        chk({tag, "_PENABLE"},   64'(PENABLE),   64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, "_PADDR"},     64'(PADDR),     64'(0));
        chk({tag, "_PWDATA"},    64'(PWDATA),    64'(0));
        chk({tag, "_PSTRB"},     64'(PSTRB),     64'(0));
        chk({tag, "_PWRITE"},    64'(PWRITE),    64'(0));
    endtask

    task automatic release_reset();
        @(negedge PCLK);
        quiet_inputs();
        PRESETn = 1'b1;
        @(posedge PCLK);
        busy = 1'b0;
        last = NR - 1;
    endtask

    initial begin
        int n;
        n_checks = 0; n_pass = 0;
        cyc = 0; t0 = 0; busy = 1'b0; last = NR - 1; cur_req = 0; rand_gate = 1'b0;
        for (int i = 0; i < NR; i++) begin head[i] = 0; tail[i] = 0; end
        quiet_inputs();
        PRESETn = 1'b0;
        #22;
        cmd_valid = '1;
        #1;
        check_all_zero("reset");
        release_reset();

        // Single write from requester 0, no wait states.
        push(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
        drain();
        // Read from requester 1 with 3 wait states.
        push(1, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 3, 32'h1234_5678, 1'b0);
        drain();
        // Both requesters contending: grants must alternate.
        for (int k = 0; k < 2; k++) begin
            push(0, 1'b1, 32'h100 + 32'(k), 32'h1111_0000 + 32'(k), 4'h3, 0, 32'h0, 1'b0);
            push(1, 1'b0, 32'h200 + 32'(k), 32'h0, 4'hC, 0, 32'h2222_0000 + 32'(k), 1'b0);
        end
        drain();
        // Stuck slave: abort, then the other requester's command is accepted.
        push(0, 1'b0, 32'h300, 32'h0, 4'h0, 1000, 32'hFFFF_FFFF, 1'b0);
        push(1, 1'b1, 32'h304, 32'hCAFE_F00D, 4'h5, 0, 32'h0, 1'b0);
        drain();
        // Slave error on a write.
        push(0, 1'b1, 32'h400, 32'h0BAD_0BAD, 4'hF, 0, 32'h0, 1'b1);
        drain();
        // Timeout boundary: ready on the last allowed cycle, and one cycle too late.
        push(1, 1'b0, 32'h500, 32'h0, 4'h0, TMO - 1, 32'h5555_AAAA, 1'b0);
        push(1, 1'b0, 32'h504, 32'h0, 4'h0, TMO, 32'h6666_BBBB, 1'b0);
        drain();

        // Randomized traffic with random valid gating.
        rand_gate = 1'b1;
        for (int k = 0; k < 60; k++) begin
            int r, sel, w;
            r   = int'($urandom_range(NR - 1));
            sel = int'($urandom_range(9));
            w   = (sel < 7) ? int'($urandom_range(3)) : (sel == 7 ? TMO - 1 : (sel == 8 ? TMO : 20));
            push(r, 1'($urandom_range(1)), $urandom, $urandom, NB'($urandom), w,
                 $urandom, 1'($urandom_range(3) == 0));
        end
        drain();
        rand_gate = 1'b0;

        // Reset asserted during ACCESS.
        push(1, 1'b0, 32'h600, 32'h0, 4'h0, 50, 32'h7777_7777, 1'b0);
        n = 0;
        while (!(busy && (cyc - t0) == 4) && n < 100) begin
            step();
            n++;
        end
        chk("reach_access", 64'(n < 100), 64'(1));
        chk("in_access_psel", 64'(PSELx & PENABLE), 64'(1));
        PRESETn   = 1'b0;
        cmd_valid = '1;
        #1;
        check_all_zero("midreset");
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("midreset_psel",      64'(PSELx),     64'(0));
        end
        busy = 1'b0;
        push(0, 1'b1, 32'h700, 32'h1357_9BDF, 4'h9, 1, 32'h0, 1'b0);
        push(1, 1'b1, 32'h704, 32'h2468_ACE0, 4'h6, 0, 32'h0, 1'b0);
        release_reset();
        chk("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master that shares one APB slave port (the AES/UART bridge register file) between NREQ command requesters, e.g. requester 0 = host config path, requester 1 = UART read-request path.
- Round-robin arbitration, latched command, standard APB SETUP/ACCESS sequencing, wait-state handling via PREADY, PSLVERR passthrough and timeout abort.
- Sits between the requester-side command/response handshakes and the APB slave pins.

Parameters:
- ADDR_WIDTH, 32, APB address width (from shared_pkg)
- DATA_WIDTH, 32, APB data width (from shared_pkg)
- NBYTES, DATA_WIDTH/8, strobe width
- NREQ, 2, number of requesters (>=2)
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort; 0 disables timeout
- TW, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  NREQ  per-requester command valid
- cmd_ready  out  NREQ  per-requester accept pulse (one-hot or zero)
- cmd_write  in  NREQ  1=write, 0=read
- cmd_addr  in  NREQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- cmd_wdata  in  NREQ*DATA_WIDTH  packed write data
- cmd_strb  in  NREQ*NBYTES  packed write strobes
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid (0 for writes)
- rsp_err  out  1  error flag, valid with rsp_valid
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PSTRB  out  NBYTES  APB strobe (forced 0 on reads)
- PWDATA  out  DATA_WIDTH  APB write data (forced 0 on reads)
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (PRESETn low, asynchronous):
  - all outputs 0
  - state=IDLE
  - last_grant=NREQ-1, so requester 0 wins first
  - timeout counter=0
- IDLE:
  - If any cmd_valid is set, grant the first requester with cmd_valid high, searching from last_grant+1 modulo NREQ.
  - Grant is combinational in IDLE: cmd_ready[g]=1 in the same cycle.
  - At the clock edge: latch addr/wdata/strb/write of g, set last_grant=g, go to SETUP.
  - cmd_ready is 0 in every other state.
- SETUP (exactly one cycle):
  - PSELx=1, PENABLE=0, PADDR/PWRITE/PSTRB/PWDATA driven from the latch.
  - Always go to ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1, address/control held stable.
  - PREADY=1: registered at the edge.
    - Next cycle rsp_valid[g]=1.
    - rsp_rdata=PRDATA on reads, 0 on writes.
    - rsp_err=PSLVERR.
    - PSELx/PENABLE=0; state goes to IDLE.
  - PREADY=0: counter increments.
    - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0, abort.
    - Abort: next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, PSELx/PENABLE=0, state goes to IDLE.
  - PREADY=1 on the final timeout cycle wins over the timeout, giving a normal completion.
- Counter clears on entry to SETUP.
- Latency with zero wait states:
  - cycle 0: accept
  - cycle 1: SETUP
  - cycle 2: ACCESS with PREADY
  - cycle 3: rsp_valid, and a new accept is possible in the same cycle (IDLE)
  - Minimum 3 cycles per transfer.
- Each wait state adds one cycle.
- cmd_valid deasserting after accept has no effect.
- A requester may keep cmd_valid high across its own rsp_valid cycle and is rearbitrated fairly.
- Reset mid-transfer: PSELx/PENABLE drop immediately (asynchronous) and no rsp_valid is issued.
- rsp_valid and rsp_err are registered, one-cycle pulses, and never multi-hot.

Decomposition:
- shared_pkg additions:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS, ARB_RESP} apb_arb_state_e
  - localparam APB_TIMEOUT_CYCLES=16
  - existing ADDR_WIDTH/DATA_WIDTH/NBYTES reused
- ARB_RESP is the single registered response cycle (equivalent to IDLE for arbitration).
- One sub-module: rr_arbiter.
  - Parameter NREQ.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the pointer register lives in the top.

Test Plan:
- Single write, requester 0: addr=0x0000_0004, wdata=0xDEAD_BEEF, strb=0xF, PREADY tied 1.
  - Required: PSELx high cycles 1-2, PENABLE high cycle 2, PWRITE=1.
  - Required: rsp_valid[0] at cycle 3, rsp_err=0.
- Read with 3 wait states, requester 1: addr=0x10, PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678 on the ready cycle.
  - Required: rsp_valid[1] at cycle 6 with rsp_rdata=0x1234_5678.
  - Required: PSTRB=0 and PWDATA=0 throughout.
- Both cmd_valid held high for 4 transfers.
  - Required: grants in order 0,1,0,1; never two grants in a row to one requester.
- PREADY stuck low with TIMEOUT_CYCLES=16.
  - Required: abort after 16 ACCESS cycles; rsp_valid with rsp_err=1 and rsp_rdata=0; PSELx=0 next cycle; next command accepted.
- PSLVERR=1 together with PREADY on a write.
  - Required: rsp_err=1 with the normal 3-cycle latency.
- PRESETn asserted during ACCESS.
  - Required: all outputs 0 immediately, no rsp_valid; after release, requester 0 is granted first.
